multi_port_registers: RTL and testbench

- Next-generation shader-core register file with NUM_READ read ports, one write port and a registered (1-cycle) read.
- Adds write-to-read bypass, an optional hardwired zero register, a per-register pending scoreboard for long-latency (FP/memory) results, and a self-clearing init sequencer.
- Sits between decode (read addresses, reservations) and writeback (write port) in the shader core.

---
 rtl/shader_regs_pkg.sv | 12 +
 rtl/register_bank_1r1w.sv | 23 ++
 rtl/multi_port_registers.sv | 132 +++++++++++++
 tb/tb_multi_port_registers.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shader_regs_pkg.sv
// Shared types and helpers for the shader-core register file.
package shader_regs_pkg;
  typedef enum logic {CLEAR, READY} reg_state_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/register_bank_1r1w.sv
// One storage copy per read port: single write, registered single read.
module register_bank_1r1w #(
  parameter int WW = 32,
  parameter int AW = 5
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o
);
  logic [WW-1:0] mem_q [2**AW];
  logic [WW-1:0] rdata_q;

  // Old data on a same-address write; the top bypasses it.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/multi_port_registers.sv
// Multi-read register file with write bypass, zero register, pending
// scoreboard and a self-clearing init sequencer.
module multi_port_registers
  import shader_regs_pkg::*;
#(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_READ      = 3,
  parameter int ZERO_REG      = 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              clear,
  output logic                              ready,
  input  logic                              write,
  input  logic [ADDRESS_WIDTH-1:0]          write_address,
  input  logic [WORD_WIDTH-1:0]             write_data,
  input  logic                              reserve,
  input  logic [ADDRESS_WIDTH-1:0]          reserve_address,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] read_address,
  output logic [NUM_READ*WORD_WIDTH-1:0]    read_data,
  output logic [NUM_READ-1:0]               read_pending
);
  localparam int  AW    = ADDRESS_WIDTH;
  localparam int  WW    = WORD_WIDTH;
  localparam int  DEPTH = depth_of(AW);
  localparam bit  ZR    = (ZERO_REG != 0);

  reg_state_t                   state_q;
  logic [AW-1:0]                cnt_q;
  logic                         ready_q;
  logic [DEPTH-1:0]             pend_q, pend_d;
  logic                         live, wr_ok, rsv_ok, bank_we;
  logic [AW-1:0]                bank_waddr;
  logic [WW-1:0]                bank_wdata, wdata_q;
  logic [NUM_READ-1:0]          vld_q, byp_q, zero_q, rpend_q;
  logic [NUM_READ-1:0][AW-1:0]  raddr;
  logic [NUM_READ-1:0][WW-1:0]  bank_rdata;

  assign live   = (state_q == READY) && !clear;
  assign wr_ok  = live && write   && !(ZR && write_address   == '0);
  assign rsv_ok = live && reserve && !(ZR && reserve_address == '0);

  // Sequencer owns the banks' write port while zeroing.
  assign bank_we    = (state_q == CLEAR) || wr_ok;
  assign bank_waddr = (state_q == CLEAR) ? cnt_q : write_address;
  assign bank_wdata = (state_q == CLEAR) ? '0    : write_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clear) cnt_q <= '0;
          else if (cnt_q == '1) begin
            state_q <= READY;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + AW'(1);
        end
        READY: begin
          if (clear) begin
            state_q <= CLEAR;
            ready_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Reserve is applied after write so a same-cycle new producer wins.
  always_comb begin
    pend_d = pend_q;
    if (!live) pend_d = '0;
    else begin
      if (wr_ok)  pend_d[write_address]   = 1'b0;
      if (rsv_ok) pend_d[reserve_address] = 1'b1;
    end
  end

  always_comb begin
    raddr = '0;
    for (int p = 0; p < NUM_READ; p++)
      raddr[p] = read_address[slice_lo(p, AW) +: AW];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= '0;
      wdata_q <= '0;
      vld_q   <= '0;
      byp_q   <= '0;
      zero_q  <= '0;
      rpend_q <= '0;
    end else begin
      pend_q  <= pend_d;
      wdata_q <= write_data;
      for (int p = 0; p < NUM_READ; p++) begin
        vld_q[p]   <= live;
        byp_q[p]   <= wr_ok && (write_address == raddr[p]);
        zero_q[p]  <= ZR && (raddr[p] == '0);
        rpend_q[p] <= live && !(ZR && raddr[p] == '0) && pend_d[raddr[p]];
      end
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_bank
    register_bank_1r1w #(.WW(WW), .AW(AW)) u_bank (
      .clock   (clock),
      .we_i    (bank_we),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata),
      .raddr_i (raddr[p]),
      .rdata_o (bank_rdata[p])
    );
  end

  always_comb begin
    read_data = '0;
    for (int p = 0; p < NUM_READ; p++)
      if (vld_q[p] && !zero_q[p])
        read_data[slice_lo(p, WW) +: WW] = byp_q[p] ? wdata_q : bank_rdata[p];
  end

  assign read_pending = rpend_q;
  assign ready        = ready_q;
endmodule

// File: tb/tb_multi_port_registers.sv
// Bench: directed vector table plus randomized traffic against a behavioural model.
module tb_multi_port_registers;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0, write = 1'b0, reserve = 1'b0;
  logic [4:0]  write_address = '0, reserve_address = '0;
  logic [31:0] write_data = '0;
  logic [14:0] read_address = '0;
  logic        ready_a, ready_b;
  logic [95:0] rd_a, rd_b;
  logic [2:0]  rp_a, rp_b;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  multi_port_registers #(.ZERO_REG(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .clear(clear), .ready(ready_a),
    .write(write), .write_address(write_address), .write_data(write_data),
    .reserve(reserve), .reserve_address(reserve_address),
    .read_address(read_address), .read_data(rd_a), .read_pending(rp_a));

  multi_port_registers #(.ZERO_REG(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .clear(clear), .ready(ready_b),
    .write(write), .write_address(write_address), .write_data(write_data),
    .reserve(reserve), .reserve_address(reserve_address),
    .read_address(read_address), .read_data(rd_b), .read_pending(rp_b));

  // Model: k=0 has a hardwired zero register, k=1 does not.
  logic [31:0] mmem  [2][32];
  bit          mpend [2][32];
  bit          mrdy;
  int          mleft;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mrdy = 1'b0;
    mleft = 32;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 32; i++) begin
        mmem[k][i] = '0;
        mpend[k][i] = 1'b0;
      end
  endfunction

  task automatic step(input bit c, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                      input bit r, input logic [4:0] ra,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    logic [4:0]  ad [3];
    logic [31:0] ed [2][3];
    bit          ep [2][3];
    bit          live, zr;
    ad[0] = a0; ad[1] = a1; ad[2] = a2;
    clear = c; write = w; write_address = wa; write_data = wd;
    reserve = r; reserve_address = ra; read_address = {a2, a1, a0};
    live = mrdy && !c;
    for (int k = 0; k < 2; k++) begin
      zr = (k == 0);
      if (live && w && !(zr && wa == 0)) mpend[k][wa] = 1'b0;
      if (live && r && !(zr && ra == 0)) mpend[k][ra] = 1'b1;
      for (int p = 0; p < 3; p++) begin
        if (!live || (zr && ad[p] == 0)) begin
          ed[k][p] = '0; ep[k][p] = 1'b0;
        end else begin
          ed[k][p] = (w && wa == ad[p]) ? wd : mmem[k][ad[p]];
          ep[k][p] = mpend[k][ad[p]];
        end
      end
      if (live && w && !(zr && wa == 0)) mmem[k][wa] = wd;
    end
    if (!mrdy) begin
      if (c) mleft = 32;
      else begin
        mleft--;
        if (mleft == 0) mrdy = 1'b1;
      end
    end else if (c) begin
      mrdy = 1'b0;
      mleft = 32;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 32; i++) begin
          mmem[k][i] = '0; mpend[k][i] = 1'b0;
        end
    end
    @(posedge clock); #1;
    chk("ready_a", 32'(ready_a), 32'(mrdy));
    chk("ready_b", 32'(ready_b), 32'(mrdy));
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("rdata_a%0d", p), rd_a[p*32 +: 32], ed[0][p]);
      chk($sformatf("rpend_a%0d", p), 32'(rp_a[p]), 32'(ep[0][p]));
      chk($sformatf("rdata_b%0d", p), rd_b[p*32 +: 32], ed[1][p]);
      chk($sformatf("rpend_b%0d", p), 32'(rp_b[p]), 32'(ep[1][p]));
    end
  endtask

  task automatic idle_step(input bit with_writes);
    step(1'b0, with_writes && $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
         with_writes && $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; clear = 1'b0; write = 1'b0; reserve = 1'b0;
    #1;
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    chk("rst_rp_a", 32'(rp_a), 32'd0);
    chk("rst_rp_b", 32'(rp_b), 32'd0);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("rst_rdata_a%0d", p), rd_a[p*32 +: 32], 32'd0);
      chk($sformatf("rst_rdata_b%0d", p), rd_b[p*32 +: 32], 32'd0);
    end
    model_reset();
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input string nm, input bit with_writes);
    int n = 0;
    while (ready_a !== 1'b1 && n < 100) begin
      idle_step(with_writes);
      n++;
    end
    chk(nm, n, 32);
  endtask

  typedef struct packed {
    logic w; logic [4:0] wa; logic [31:0] wd; logic r; logic [4:0] ra;
    logic [4:0] a0, a1, a2;
    logic [31:0] e0, e1, e2; logic [2:0] ep;
    logic [31:0] eb; logic epb;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic r, input logic [4:0] ra,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [2:0] ep, input logic [31:0] eb, input logic epb);
    vec_t v;
    v = '{w, wa, wd, r, ra, a0, a1, a2, e0, e1, e2, ep, eb, epb};
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    tbl[0] = mk(0, 0, 0,            0, 0, 5, 17, 31, 0, 0, 0, 3'b000, 0, 0);
    tbl[1] = mk(1, 7, 32'hDEADBEEF, 0, 0, 5, 17, 31, 0, 0, 0, 3'b000, 0, 0);
    tbl[2] = mk(0, 0, 0,            0, 0, 7, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 32'hDEADBEEF, 0);
    tbl[3] = mk(1, 3, 32'h12345678, 0, 0, 7, 3, 7, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 3'b000, 32'hDEADBEEF, 0);
    tbl[4] = mk(0, 0, 0,            1, 9, 9, 3, 0, 0, 32'h12345678, 0, 3'b001, 0, 1);
    tbl[5] = mk(0, 0, 0,            0, 0, 9, 9, 9, 0, 0, 0, 3'b111, 0, 1);
    tbl[6] = mk(1, 9, 32'hA5,       0, 0, 9, 9, 3, 32'hA5, 32'hA5, 32'h12345678, 3'b000, 32'hA5, 0);
    tbl[7] = mk(1, 9, 32'h11,       1, 9, 9, 7, 9, 32'h11, 32'hDEADBEEF, 32'h11, 3'b101, 32'h11, 1);
    tbl[8] = mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 9, 0, 0, 32'h11, 3'b100, 32'hFFFFFFFF, 1);
    tbl[9] = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'hFFFFFFFF, 1);

    #2;
    do_reset();
    wait_ready("init_cycles", 1'b0);

    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r, tbl[i].ra, tbl[i].a0, tbl[i].a1, tbl[i].a2);
      chk($sformatf("tbl%0d_d0", i), rd_a[31:0],  tbl[i].e0);
      chk($sformatf("tbl%0d_d1", i), rd_a[63:32], tbl[i].e1);
      chk($sformatf("tbl%0d_d2", i), rd_a[95:64], tbl[i].e2);
      chk($sformatf("tbl%0d_p", i), 32'(rp_a), 32'(tbl[i].ep));
      chk($sformatf("tbl%0d_b0", i), rd_b[31:0], tbl[i].eb);
      chk($sformatf("tbl%0d_bp0", i), 32'(rp_b[0]), 32'(tbl[i].epb));
    end

    // Clear after loading regs 1..4; the write in the clear cycle is dropped.
    for (int i = 1; i <= 4; i++) step(0, 1, 5'(i), 32'h100 + i, 0, 0, 1, 2, 3);
    step(0, 0, 0, 0, 0, 0, 1, 2, 4);
    chk("loaded_r4", rd_a[95:64], 32'h104);
    step(1, 1, 1, 32'hBAD, 1, 2, 1, 2, 3);
    wait_ready("clear_cycles", 1'b1);
    for (int i = 0; i < 32; i += 3) step(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 1), 5'(i + 2));
    step(0, 0, 0, 0, 0, 0, 1, 2, 3);
    chk("cleared_r1", rd_a[31:0], 32'd0);
    chk("cleared_r3_b", rd_b[95:64], 32'd0);

    // Reset mid-operation, then clear restart and reset mid-CLEAR.
    step(0, 1, 5, 32'hCAFE, 1, 6, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 5, 6, 5);
    chk("pre_rst_r5", rd_a[31:0], 32'hCAFE);
    do_reset();
    wait_ready("rst_op_cycles", 1'b1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) idle_step(1'b1);
    step(1, 1, 4, 32'h44, 0, 0, 4, 4, 4);
    wait_ready("reclear_cycles", 1'b1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) idle_step(1'b1);
    do_reset();
    wait_ready("rst_clear_cycles", 1'b1);

    // Random traffic on a narrow address range to provoke bypass and scoreboard hits.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] wa, ra, a0, a1, a2;
      wa = 5'($urandom_range(0, 7));
      ra = 5'($urandom_range(0, 7));
      a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 31));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
           $urandom_range(0, 2) == 0, ra, a0, a1, a2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
